delay_line_probe: RTL and testbench

- Transmit-side counterpart to the delay line.
- Emits a carrier-modulated IR test burst on tx_out, which drives the IR emitter feeding the line input.
- Watches the returned signal rx_in and measures the round-trip delay in clk cycles.
- Sits beside delay_line under the top-level wrapper, on the PLL clock, for bring-up and latency calibration.

---
 rtl/delay_line_pkg.sv | 21 ++
 rtl/rx_edge_sync.sv | 27 ++
 rtl/delay_line_probe.sv | 140 ++++++++++++++
 tb/tb_delay_line_probe.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/delay_line_pkg.sv
// rtl/delay_line_pkg.sv - shared types and defaults for the delay line and its probe
package delay_line_pkg;

    localparam int DEF_CLK_HZ        = 100_000_000;
    localparam int DEF_CARRIER_HALF  = 1316;
    localparam int DEF_BURST_PERIODS = 20;
    localparam int DEF_COUNT_W       = 24;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BURST  = 2'd1,
        ST_LISTEN = 2'd2,
        ST_DONE   = 2'd3
    } probe_state_t;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rx_edge_sync.sv
// rtl/rx_edge_sync.sv - two-flop synchroniser with rising-edge detector
module rx_edge_sync (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic rise
);

    logic sync1;
    logic sync2;
    logic prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
        end else begin
            sync1 <= async_in;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign rise = sync2 & ~prev;

endmodule

// File: rtl/delay_line_probe.sv
// rtl/delay_line_probe.sv - IR burst transmitter and round-trip echo delay meter
module delay_line_probe
    import delay_line_pkg::*;
#(
    parameter int CARRIER_HALF  = DEF_CARRIER_HALF,
    parameter int BURST_PERIODS = DEF_BURST_PERIODS,
    parameter int COUNT_W       = DEF_COUNT_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic               busy,
    output logic               tx_out,
    input  logic               rx_in,
    output logic               done,
    output logic               echo_valid,
    output logic [COUNT_W-1:0] echo_delay,
    output logic               timeout
);

    localparam int HALF_W = cnt_width(CARRIER_HALF);
    localparam int PER_W  = cnt_width(BURST_PERIODS);
    localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(CARRIER_HALF - 1);
    localparam logic [PER_W-1:0]  PER_LAST  = PER_W'(BURST_PERIODS - 1);

    probe_state_t       state;
    probe_state_t       state_nxt;
    logic [HALF_W-1:0]  half_cnt;
    logic               phase;
    logic [PER_W-1:0]   period_cnt;
    logic [COUNT_W-1:0] count;
    logic               rx_rise;
    logic               capture;
    logic               burst_end;
    logic               count_max;

    rx_edge_sync u_rx_sync (
        .clk      (clk),
        .reset    (reset),
        .async_in (rx_in),
        .rise     (rx_rise)
    );

    assign count_max = &count;
    // Only the first rise of a measurement is taken; echo_valid disarms the rest.
    assign capture   = rx_rise && !echo_valid &&
                       (state == ST_BURST || state == ST_LISTEN);
    assign burst_end = (state == ST_BURST) && phase &&
                       (half_cnt == HALF_LAST) && (period_cnt == PER_LAST);

    assign busy   = (state != ST_IDLE);
    assign done   = (state == ST_DONE);
    assign tx_out = (state == ST_BURST) && !phase;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_BURST;
                end
            end
            ST_BURST: begin
                if (burst_end) begin
                    state_nxt = (echo_valid || capture) ? ST_DONE : ST_LISTEN;
                end
            end
            ST_LISTEN: begin
                if (capture || count_max) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            half_cnt   <= '0;
            phase      <= 1'b0;
            period_cnt <= '0;
            count      <= '0;
            echo_valid <= 1'b0;
            echo_delay <= '0;
            timeout    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        half_cnt   <= '0;
                        phase      <= 1'b0;
                        period_cnt <= '0;
                        count      <= '0;
                        echo_valid <= 1'b0;
                        echo_delay <= '0;
                        timeout    <= 1'b0;
                    end
                end
                ST_BURST, ST_LISTEN: begin
                    if (!count_max) begin
                        count <= count + COUNT_W'(1);
                    end
                    if (state == ST_BURST) begin
                        if (half_cnt == HALF_LAST) begin
                            half_cnt <= '0;
                            phase    <= ~phase;
                            if (phase) begin
                                period_cnt <= period_cnt + PER_W'(1);
                            end
                        end else begin
                            half_cnt <= half_cnt + HALF_W'(1);
                        end
                    end
                    if (capture) begin
                        echo_valid <= 1'b1;
                        echo_delay <= count;
                    end else if (state == ST_LISTEN && count_max) begin
                        timeout <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_delay_line_probe.sv
// tb/tb_delay_line_probe.sv - randomized self-checking bench for delay_line_probe
module tb_delay_line_probe;

    localparam int CH        = 4;
    localparam int BP        = 3;
    localparam int CW        = 8;
    localparam int BURST_LEN = 2 * CH * BP;
    localparam int CNT_MAX   = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          rx_in;
    logic          busy;
    logic          tx_out;
    logic          done;
    logic          echo_valid;
    logic [CW-1:0] echo_delay;
    logic          timeout;

    int n_checks = 0;
    int n_errors = 0;

    bit plan [0:299];
    bit plan_init;
    bit rx_log [$];
    bit last_valid;
    int last_delay;
    bit last_timeout;

    delay_line_probe #(
        .CARRIER_HALF  (CH),
        .BURST_PERIODS (BP),
        .COUNT_W       (CW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .busy       (busy),
        .tx_out     (tx_out),
        .rx_in      (rx_in),
        .done       (done),
        .echo_valid (echo_valid),
        .echo_delay (echo_delay),
        .timeout    (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // rx_in value driven during a cycle is sampled at the edge ending it.
    task automatic tick(input bit v);
        @(posedge clk);
        #1;
        rx_in = v;
        rx_log.push_back(v);
    endtask

    function automatic void set_plan(input bit init, input int ta, input int tb, input int tc);
        bit v;
        plan_init = init;
        for (int c = 0; c < 300; c++) begin
            v = init;
            if (ta >= 0 && c >= ta) v = ~v;
            if (tb >= 0 && c >= tb) v = ~v;
            if (tc >= 0 && c >= tc) v = ~v;
            plan[c] = v;
        end
    endfunction

    function automatic bit lvl(input int j, input int base);
        if (j < 0) return rx_log[base + j];
        return plan[j];
    endfunction

    task automatic check_results(input string pfx);
        check({pfx, "_echo_valid"}, echo_valid, last_valid);
        check({pfx, "_echo_delay"}, echo_delay, last_delay);
        check({pfx, "_timeout"}, timeout, last_timeout);
    endtask

    // One measurement: idle cycles, start pulse, then every busy cycle checked.
    task automatic run(input int idle, input bit spurious);
        int k;
        int base;
        int end_c;
        for (int i = 0; i < idle; i++) begin
            tick(plan_init);
            check("hold_echo_valid", echo_valid, last_valid);
        end
        base = rx_log.size();
        // A rise seen by the detector in cycle c needs rx high at c-2 and low at c-3.
        k = -1;
        for (int c = 0; c <= CNT_MAX; c++) begin
            if (k < 0 && lvl(c - 2, base) && !lvl(c - 3, base)) k = c;
        end
        if (k < 0)               end_c = CNT_MAX + 1;
        else if (k < BURST_LEN)  end_c = BURST_LEN;
        else                     end_c = k + 1;
        if (k == BURST_LEN - 1)  end_c = BURST_LEN;

        start = 1'b1;
        tick(plan[0]);
        start = 1'b0;
        check("clr_echo_valid", echo_valid, 0);
        check("clr_echo_delay", echo_delay, 0);
        check("clr_timeout", timeout, 0);
        for (int c = 0; c <= end_c + 1; c++) begin
            check($sformatf("tx_out@%0d", c), tx_out, (c < BURST_LEN) && ((c / CH) % 2 == 0));
            check($sformatf("busy@%0d", c), busy, c <= end_c);
            check($sformatf("done@%0d", c), done, c == end_c);
            if (c <= end_c) begin
                start = spurious ? bit'($urandom_range(0, 1)) : 1'b0;
                tick(plan[c + 1]);
            end
        end
        start = 1'b0;
        last_valid   = (k >= 0);
        last_delay   = (k >= 0) ? k : 0;
        last_timeout = (k < 0);
        check_results("result");
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        rx_in = 1'b0;
        for (int i = 0; i < 3; i++) rx_log.push_back(1'b0);
        last_valid   = 1'b0;
        last_delay   = 0;
        last_timeout = 1'b0;
        for (int i = 0; i < 3; i++) tick(1'b0);
        check("rst_busy", busy, 0);
        check("rst_tx_out", tx_out, 0);
        check("rst_done", done, 0);
        check_results("rst");
        reset = 1'b0;

        set_plan(1'b0, -1, -1, -1);  run(3, 1'b0);
        set_plan(1'b0, 40, -1, -1);  run(3, 1'b1);
        set_plan(1'b0, 10, 20, 30);  run(3, 1'b0);
        set_plan(1'b1, -1, -1, -1);  run(3, 1'b0);
        set_plan(1'b1, 50, 60, -1);  run(3, 1'b0);
        set_plan(1'b1, 70, 80, -1);  run(0, 1'b1);
        set_plan(1'b0, 253, -1, -1); run(3, 1'b0);
        set_plan(1'b0, 254, -1, -1); run(3, 1'b0);
        set_plan(1'b0, 20, -1, -1);  run(3, 1'b0);

        // Reset in the middle of a burst, with a stray start in cycle 5.
        set_plan(1'b0, -1, -1, -1);
        tick(1'b0);
        start = 1'b1;
        tick(1'b0);
        start = 1'b0;
        for (int c = 0; c <= 5; c++) begin
            check($sformatf("pre_rst_tx@%0d", c), tx_out, (c / CH) % 2 == 0);
            start = (c == 5);
            tick(1'b0);
        end
        start = 1'b0;
        reset = 1'b1;
        tick(1'b0);
        check("mid_rst_tx_out", tx_out, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        last_valid   = 1'b0;
        last_delay   = 0;
        last_timeout = 1'b0;
        check_results("mid_rst");
        reset = 1'b0;
        set_plan(1'b0, 30, -1, -1); run(3, 1'b0);

        for (int r = 0; r < 20; r++) begin
            set_plan(bit'($urandom_range(0, 1)),
                     ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, 280)),
                     ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, 280)),
                     ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 280)) : -1);
            run(int'($urandom_range(0, 4)), bit'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
